seq_div: RTL and testbench

Parametrised multi-cycle integer divider. It succeeds the team's fixed 8/4-bit combinational divider, which accepted only a non-negative divisor. This block adds generic widths, a signed or unsigned mode with a signed divisor allowed, a start/done handshake, and divide-by-zero and overflow flags. It sits on the datapath as a shared arithmetic unit. The issuing controller holds operands stable only in the start cycle.

---
 rtl/seq_div.sv | 166 ++++++++++++++++
 tb/tb_seq_div.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring integer divider, signed or unsigned.
//   clk, rst_n           : rising-edge clock, async active-low reset
//   start                : request, sampled only while busy=0
//   signed_mode          : 1 = two's-complement operands (sampled with start)
//   dividend [DW], divisor [VW] : operands, sampled with start only
//   quotient [DW], remainder [VW] : registered results, held until next FIX
//   done                 : one-cycle pulse, results and flags valid
//   busy                 : operation in flight
//   div_by_zero, overflow: result flags, valid with done, held until next accept
// Operands are reduced to magnitudes at accept, divided in DW shift-subtract
// steps, and signs are applied in a single FIX cycle.
module seq_div #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          done,
  output logic          busy,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   acc_q, acc_d;      // partial remainder
  logic [DW-1:0] dvd_q, dvd_d;      // |dividend| shifts out MSB-first, quotient bits shift in
  logic [VW-1:0] dvs_q, dvs_d;      // |divisor|
  logic          nq_q, nq_d;        // quotient negative
  logic          nr_q, nr_d;        // remainder negative (dividend sign)
  logic          zero_q, zero_d;    // pending divide-by-zero
  logic          ov_q, ov_d;        // pending overflow
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [VW:0]   shifted;
  logic          qbit;
  logic          sign_a, sign_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    shifted = '0;
    qbit    = 1'b0;
    sign_a  = signed_mode & dividend[DW-1];
    sign_b  = signed_mode & divisor[VW-1];

    case (state_q)
      IDLE: begin
        if (start) begin
          // Negating -2^(N-1) yields 2^(N-1), which is correct as an unsigned magnitude.
          dvd_d   = sign_a ? -dividend : dividend;
          dvs_d   = sign_b ? -divisor : divisor;
          nq_d    = sign_a ^ sign_b;
          nr_d    = sign_a;
          acc_d   = '0;
          zero_d  = (divisor == '0);
          ov_d    = signed_mode && (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(DW);
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        shifted = (acc_q << 1) | {{VW{1'b0}}, dvd_q[DW-1]};
        if (shifted >= {1'b0, dvs_q}) begin
          acc_d = shifted - {1'b0, dvs_q};
          qbit  = 1'b1;
        end else begin
          acc_d = shifted;
        end
        dvd_d = {dvd_q[DW-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          quo_d = '1;
          rem_d = '0;
        end else begin
          // The overflow case falls out naturally: 2^(DW-1) positive wraps to 100..0.
          quo_d = nq_q ? -dvd_q : dvd_q;
          rem_d = nr_q ? -acc_q[VW-1:0] : acc_q[VW-1:0];
        end
        dbz_d   = zero_q;
        ovf_d   = ov_q & ~zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vector table on an 8/4 divider, hand sequences for
// ignored start, back-to-back, async reset abort, and a random 16/8 sweep
// checked against an integer reference.
module tb_seq_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_start, a_sm;
  logic [7:0] a_dvd, a_q;
  logic [3:0] a_dvs, a_r;
  logic       a_done, a_busy, a_dbz, a_ovf;

  logic        b_start, b_sm;
  logic [15:0] b_dvd, b_q;
  logic [7:0]  b_dvs, b_r;
  logic        b_done, b_busy, b_dbz, b_ovf;

  seq_div #(.DW(8), .VW(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .signed_mode(a_sm),
    .dividend(a_dvd), .divisor(a_dvs), .quotient(a_q), .remainder(a_r),
    .done(a_done), .busy(a_busy), .div_by_zero(a_dbz), .overflow(a_ovf));

  seq_div #(.DW(16), .VW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .signed_mode(b_sm),
    .dividend(b_dvd), .divisor(b_dvs), .quotient(b_q), .remainder(b_r),
    .done(b_done), .busy(b_busy), .div_by_zero(b_dbz), .overflow(b_ovf));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] r_q, r_r;
  logic        r_dbz, r_ovf, r_busy;
  int          lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive a request for one cycle, then scramble the operands.
  task automatic issue(input bit wide, input bit sm, input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    if (wide) begin
      b_start = 1'b1; b_sm = sm; b_dvd = dvd[15:0]; b_dvs = dvs[7:0];
    end else begin
      a_start = 1'b1; a_sm = sm; a_dvd = dvd[7:0]; a_dvs = dvs[3:0];
    end
    @(posedge clk); #1;
    a_start = 1'b0; a_sm = 1'($urandom); a_dvd = 8'($urandom);  a_dvs = 4'($urandom);
    b_start = 1'b0; b_sm = 1'($urandom); b_dvd = 16'($urandom); b_dvs = 8'($urandom);
  endtask

  task automatic wait_done(input bit wide, input int budget);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (wide ? b_done : a_done) break;
      if (lat >= budget) begin
        n_cmp++; n_err++;
        $display("FAIL done_timeout: got no done after %0d cycles want done", lat);
        break;
      end
    end
    if (wide) begin
      r_q = 32'(b_q); r_r = 32'(b_r); r_dbz = b_dbz; r_ovf = b_ovf; r_busy = b_busy;
    end else begin
      r_q = 32'(a_q); r_r = 32'(a_r); r_dbz = a_dbz; r_ovf = a_ovf; r_busy = a_busy;
    end
  endtask

  // Reference for the 16/8 instance: {dbz, ovf, rem[7:0], quo[15:0]}.
  function automatic logic [25:0] ref16(input bit sm, input logic [15:0] a, input logic [7:0] b);
    int sa, sb;
    logic [15:0] q;
    logic [7:0]  r;
    if (b == 8'h00) return {2'b10, 8'h00, 16'hFFFF};
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) return {2'b01, 8'h00, 16'h8000};
      q = 16'(sa / sb);
      r = 8'(sa % sb);
    end else begin
      q = 16'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
    end
    return {2'b00, r, q};
  endfunction

  typedef struct {
    bit         sm;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    bit         dbz;
    bit         ovf;
    int         lat;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{1'b1, 8'h1A, 4'h5, 8'h05, 4'h1, 1'b0, 1'b0, 9};  //  26 / 5
    tv[1]  = '{1'b1, 8'h9A, 4'h7, 8'hF2, 4'hC, 1'b0, 1'b0, 9};  // -102 / 7
    tv[2]  = '{1'b1, 8'h9A, 4'h2, 8'hCD, 4'h0, 1'b0, 1'b0, 9};  // -102 / 2
    tv[3]  = '{1'b1, 8'h1B, 4'hC, 8'hFA, 4'h3, 1'b0, 1'b0, 9};  //  27 / -4
    tv[4]  = '{1'b0, 8'h9A, 4'h7, 8'h16, 4'h0, 1'b0, 1'b0, 9};  // 154 / 7
    tv[5]  = '{1'b1, 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 9};  // -128 / -1
    tv[6]  = '{1'b1, 8'h80, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0, 1};  // signed / 0
    tv[7]  = '{1'b0, 8'h80, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0, 1};  // unsigned / 0
    tv[8]  = '{1'b0, 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0, 9};  // 255 / 15
    tv[9]  = '{1'b0, 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 1'b0, 9};  // 255 / 1, no overflow
    tv[10] = '{1'b1, 8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 9};  // -128 / 1
    tv[11] = '{1'b1, 8'hF9, 4'h2, 8'hFD, 4'hF, 1'b0, 1'b0, 9};  //  -7 / 2
    tv[12] = '{1'b1, 8'h07, 4'h8, 8'h00, 4'h7, 1'b0, 1'b0, 9};  //   7 / -8
    tv[13] = '{1'b0, 8'h64, 4'h8, 8'h0C, 4'h4, 1'b0, 1'b0, 9};  // 100 / 8

    rst_n = 1'b0;
    a_start = 1'b0; a_sm = 1'b0; a_dvd = '0; a_dvs = '0;
    b_start = 1'b0; b_sm = 1'b0; b_dvd = '0; b_dvs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient",  32'(a_q),    32'h0);
    chk("rst_remainder", 32'(a_r),    32'h0);
    chk("rst_done",      32'(a_done), 32'h0);
    chk("rst_busy",      32'(a_busy), 32'h0);
    chk("rst_dbz",       32'(a_dbz),  32'h0);
    chk("rst_ovf",       32'(a_ovf),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(1'b0, tv[i].sm, 32'(tv[i].dvd), 32'(tv[i].dvs));
      wait_done(1'b0, 40);
      chk($sformatf("v%0d_quotient", i),  r_q,          32'(tv[i].q));
      chk($sformatf("v%0d_remainder", i), r_r,          32'(tv[i].r));
      chk($sformatf("v%0d_dbz", i),       32'(r_dbz),   32'(tv[i].dbz));
      chk($sformatf("v%0d_ovf", i),       32'(r_ovf),   32'(tv[i].ovf));
      chk($sformatf("v%0d_busy", i),      32'(r_busy),  32'h0);
      chk($sformatf("v%0d_latency", i),   32'(lat),     32'(tv[i].lat));
      // done must be a single pulse while results and flags stay put
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(a_done), 32'h0);
      chk($sformatf("v%0d_q_hold", i),     32'(a_q),    32'(tv[i].q));
      chk($sformatf("v%0d_flag_hold", i),  32'({a_dbz, a_ovf}), 32'({tv[i].dbz, tv[i].ovf}));
    end

    // start pulsed while busy is ignored
    issue(1'b0, 1'b1, 32'h1A, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    a_start = 1'b1; a_sm = 1'b0; a_dvd = 8'h77; a_dvs = 4'h3;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_done(1'b0, 40);
    chk("ign_quotient",  r_q,           32'h05);
    chk("ign_remainder", r_r,           32'h1);
    chk("ign_latency",   32'(lat + 3),  32'd9);
    chk("b2b_done_high", 32'(a_done),   32'h1);

    // start issued during the done cycle is accepted
    issue(1'b0, 1'b1, 32'h9A, 32'h7);
    wait_done(1'b0, 40);
    chk("b2b_quotient",  r_q,      32'hF2);
    chk("b2b_remainder", r_r,      32'hC);
    chk("b2b_latency",   32'(lat), 32'd9);

    // async reset mid-operation aborts with no done
    issue(1'b0, 1'b1, 32'h9A, 32'h2);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_quotient",  32'(a_q),    32'h0);
    chk("abort_remainder", 32'(a_r),    32'h0);
    chk("abort_done",      32'(a_done), 32'h0);
    chk("abort_busy",      32'(a_busy), 32'h0);
    chk("abort_flags",     32'({a_dbz, a_ovf}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        if (a_done || a_busy) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'h0);
    end
    issue(1'b0, 1'b0, 32'h64, 32'h8);
    wait_done(1'b0, 40);
    chk("post_rst_quotient",  r_q,      32'h0C);
    chk("post_rst_remainder", r_r,      32'h4);
    chk("post_rst_latency",   32'(lat), 32'd9);

    // 16/8 sweep: fixed corners then random operands
    for (int i = 0; i < 26; i++) begin
      bit          sm;
      logic [15:0] a;
      logic [7:0]  b;
      logic [25:0] e;
      if (i == 0)      begin sm = 1'b1; a = 16'h8000; b = 8'hFF; end
      else if (i == 1) begin sm = 1'b0; a = 16'h1234; b = 8'h00; end
      else begin
        sm = 1'($urandom);
        a  = 16'($urandom);
        b  = (i % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      e = ref16(sm, a, b);
      issue(1'b1, sm, 32'(a), 32'(b));
      wait_done(1'b1, 40);
      chk($sformatf("w%0d_quotient", i),  r_q,         32'(e[15:0]));
      chk($sformatf("w%0d_remainder", i), r_r,         32'(e[23:16]));
      chk($sformatf("w%0d_flags", i),     32'({r_dbz, r_ovf}), 32'(e[25:24]));
      chk($sformatf("w%0d_latency", i),   32'(lat),    (b == 8'h00) ? 32'd1 : 32'd17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
